valve_scheduler: RTL
====================

Name: valve_scheduler

Overview:
- Serializes reward-valve pulse requests for the four maze valves, so that at most one valve is open at any time. This limits pressure drop on the shared water reservoir.
- Sits between the host trigger endpoints (clk_1mhz domain) and the valve outputs, replacing the per-valve drivers.
- Requests are latched, arbitrated round-robin, then played out as N open pulses per request, separated by a fixed closed gap.

Parameters:
NUM_VALVES, 4, number of requesters/valves; fixed at 4 for this design.
LEN_W, 24, width of each pulse-length field, in clk cycles (1 us each).
GAP_CYCLES, 20_000, closed time after every pulse; values <1 are treated as 1.

Ports:
clk  input  1  system clock (clk_1mhz)
reset  input  1  asynchronous, active-high; clears all state
trig  input  4  single-cycle request pulse per valve; bit i = valve i
abort  input  1  single-cycle; closes the valve and flushes all requests
pulse_len  input  96  packed open lengths; valve i uses [LEN_W*i +: LEN_W]
repeat_count  input  16  packed pulse counts; valve i uses [4*i +: 4]; 0 is treated as 1
valve  output  4  valve drive; at most one bit high; registered
pending  output  4  latched, not-yet-granted requests; registered
busy  output  1  high in OPEN or GAP
active  output  2  index of the currently or last granted valve

Behaviour:
- Reset values: valve=0, pending=0, busy=0, active=0, state=IDLE, rr_last=3 (valve 0 has first priority).
- Request latch:
  - trig[i] sampled at edge E sets pending[i] after E.
  - A repeated trig for an already-pending valve coalesces (no count).
  - A trig for the valve currently being served sets pending[i] again, so that valve is served once more later.
- Arbiter:
  - Round-robin, starting from rr_last+1 mod 4, taking the first set pending bit.
  - Evaluated only in IDLE.
  - On grant, rr_last <= granted index.
- States:
  - IDLE: if pending != 0, grant g:
    - active<=g; clear pending[g]; snapshot len=pulse_len[g] and reps=max(repeat_count[g],1).
    - If len==0: stay IDLE; the request is consumed with no valve activity and no gap.
    - Else: go to OPEN with valve[g]=1 and len_cnt=len.
    - If trig[g] arrives on the grant cycle, the set wins: pending[g] stays 1.
  - OPEN: decrement len_cnt each cycle. When len_cnt reaches 1, at the next edge: valve<=0, reps<=reps-1, gap_cnt<=GAP_CYCLES, go to GAP. valve[g] is high exactly len cycles.
  - GAP: valve=0. Decrement gap_cnt; when it expires:
    - if reps>0, go to OPEN (len_cnt=len snapshot, valve[g]=1);
    - else go to IDLE.
  - The gap always follows the final pulse, guaranteeing ≥GAP_CYCLES closed between different valves.
- Latency: trig at edge E0 -> pending after E0 -> grant at E1 -> valve high after E1, if IDLE with no higher-priority pending.
- Snapshot rule: changes to pulse_len or repeat_count during service have no effect until the next grant.
- abort: at the next edge valve<=0, pending<=0, busy<=0, state<=IDLE; rr_last is kept. A trig on the same cycle as abort is discarded.
- Async reset asserted mid-pulse: valve drops immediately, without waiting for a clock edge.
- Invariant: $countones(valve) ≤ 1 on every cycle.

Optional Feature:
- Macro: VALVE_SCHED_STATS_EN.
- When defined:
  - Adds output port `served_total` (32, total completed open pulses, wrapping at 2^32).
  - Adds output port `coalesced` (16, trig pulses hitting an already-pending bit, saturating at 16'hFFFF).
  - Both outputs are cleared by reset only.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then a single trig[0] with pulse_len0=5, repeat0=1, GAP=3 -> valve[0] high exactly 5 cycles starting 2 edges after trig; busy high 5+3 cycles; pending[0] visible for 1 cycle.
- trig=4'b1111 in one cycle, all len=4, repeat=2, GAP=3 -> service order 0,1,2,3; each valve gives 2 pulses of 4 cycles with 3-cycle gaps; never two valve bits high at once.
- Round-robin: serve valve 2, then trig[1] and trig[3] together -> valve 3 is granted before valve 1.
- trig[1] during valve 1's OPEN, plus a duplicate trig[1] -> one extra service of valve 1 after the gap; the coalesced counter increments by 1 when VALVE_SCHED_STATS_EN is defined.
- Edge fields: len=0 on valve 2 -> pending[2] cleared, valve stays 0, no busy. repeat=0 on valve 3 -> exactly 1 pulse.
- abort at cycle 3 of a 10-cycle pulse with pending=4'b0110 -> valve 0 after the next edge, pending=0, IDLE. Separately, async reset mid-pulse -> valve 0 with no clock edge.

Source files
------------

// File: rtl/valve_scheduler_if.sv
// Host-side request/valve bundle for valve_scheduler.
// Host drives requests and timing fields (master); the scheduler drives valves and status (slave).
interface valve_scheduler_if #(
    parameter int LEN_W = 24
);
    logic [3:0]         trig;
    logic               abort;
    logic [4*LEN_W-1:0] pulse_len;
    logic [15:0]        repeat_count;
    logic [3:0]         valve;
    logic [3:0]         pending;
    logic               busy;
    logic [1:0]         active;

    modport master (
        output trig, abort, pulse_len, repeat_count,
        input  valve, pending, busy, active
    );

    modport slave (
        input  trig, abort, pulse_len, repeat_count,
        output valve, pending, busy, active
    );
endinterface

// File: rtl/valve_scheduler.sv
// Round-robin reward-valve serializer: at most one valve open; trig -> valve high two edges later when idle.
// No backpressure: requests are latched and coalesced. VALVE_SCHED_STATS_EN adds served_total/coalesced.
module valve_scheduler #(
    parameter int NUM_VALVES = 4,
    parameter int LEN_W      = 24,
    parameter int GAP_CYCLES = 20_000
) (
    input  logic              clk,
    input  logic              reset,
    valve_scheduler_if.slave  bus
`ifdef VALVE_SCHED_STATS_EN
    , output logic [31:0]     served_total
    , output logic [15:0]     coalesced
`endif
);
    typedef enum logic [1:0] {IDLE, OPEN, GAP} state_t;

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = $clog2(GAP_EFF + 1);

    state_t                 state, state_nxt;
    logic [NUM_VALVES-1:0]  pending_q, valve_q, clr;
    logic [1:0]             active_q, rr_last, grant;
    logic                   grant_vld;
    logic [LEN_W-1:0]       len_snap, len_cnt, grant_len;
    logic [3:0]             reps, grant_reps;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   pulse_end, gap_end;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        // Scan starts just after the last winner; k == NUM_VALVES wraps back to rr_last itself.
        for (int k = 1; k <= NUM_VALVES; k++) begin
            if (!grant_vld && pending_q[rr_last + 2'(k)]) begin
                grant     = rr_last + 2'(k);
                grant_vld = 1'b1;
            end
        end
        grant_len  = bus.pulse_len[LEN_W*grant +: LEN_W];
        grant_reps = (bus.repeat_count[4*grant +: 4] == 4'd0) ? 4'd1 : bus.repeat_count[4*grant +: 4];
        pulse_end  = (state == OPEN) && (len_cnt == LEN_W'(1));
        gap_end    = (state == GAP) && (gap_cnt == GAP_W'(1));
        clr        = '0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    clr[grant] = 1'b1;
                    if (grant_len != '0) state_nxt = OPEN;
                end
            end
            OPEN:    if (pulse_end) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = (reps != 4'd0) ? OPEN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            valve_q   <= '0;
            active_q  <= '0;
            rr_last   <= 2'd3;
            len_snap  <= '0;
            len_cnt   <= '0;
            reps      <= '0;
            gap_cnt   <= '0;
        end else if (bus.abort) begin
            pending_q <= '0;
            valve_q   <= '0;
        end else begin
            // A trig on the grant cycle re-sets the bit being cleared.
            pending_q <= (pending_q & ~clr) | bus.trig;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        active_q <= grant;
                        rr_last  <= grant;
                        len_snap <= grant_len;
                        len_cnt  <= grant_len;
                        reps     <= grant_reps;
                        if (grant_len != '0) valve_q <= NUM_VALVES'(1) << grant;
                    end
                end
                OPEN: begin
                    if (pulse_end) begin
                        valve_q <= '0;
                        reps    <= reps - 4'd1;
                        gap_cnt <= GAP_W'(GAP_EFF);
                    end else begin
                        len_cnt <= len_cnt - LEN_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (reps != 4'd0) begin
                            valve_q <= NUM_VALVES'(1) << active_q;
                            len_cnt <= len_snap;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: valve_q <= '0;
            endcase
        end
    end

`ifdef VALVE_SCHED_STATS_EN
    logic [16:0] coal_sum;
    assign coal_sum = {1'b0, coalesced} + 17'($countones(bus.trig & pending_q & ~clr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_total <= '0;
            coalesced    <= '0;
        end else if (!bus.abort) begin
            if (pulse_end) served_total <= served_total + 32'd1;
            coalesced <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
        end
    end
`endif

    assign bus.valve   = valve_q;
    assign bus.pending = pending_q;
    assign bus.busy    = (state != IDLE);
    assign bus.active  = active_q;
endmodule
